// File: rtl/datamem_pipe.sv
// ---------------------------------------------------------------------------
// datamem_pipe
//
// Pipelined little-endian data memory for the CPU datapath. One load or store
// request is taken per cycle and every accepted request gets exactly one
// response, in order, READ_LAT cycles later. Bad size, misaligned and
// out-of-bounds requests return an error response and never touch storage.
// Loads come back sign- or zero-extended to DATA_W.
//
// Parameters
//   MEM_BYTES  storage size in bytes (power of two, > 8)
//   ADDR_W     request address width
//   DATA_W     data width (power of two, 8..64)
//   READ_LAT   request-to-response latency, 1 or 2
//
// Ports
//   clk         clock, all state updates on posedge
//   reset_n     asynchronous active-low reset (pipeline only, not storage)
//   req_valid   request present
//   req_ready   request accepted when req_valid && req_ready at posedge
//   req_write   1 = store, 0 = load
//   req_signed  loads only: 1 = sign-extend, 0 = zero-extend
//   req_addr    byte address
//   req_size    transfer size in bytes: 1, 2, 4 or 8 (<= DATA_W/8)
//   req_wdata   store data, byte 0 goes to req_addr
//   resp_valid  response present
//   resp_ready  response consumed when resp_valid && resp_ready at posedge
//   resp_write  echo of req_write
//   resp_err    request was rejected, storage unchanged
//   resp_rdata  extended load data, 0 for stores and errors
//
// Handshake: a transfer happens on a posedge where valid && ready are both
// high. The producer holds its payload stable while valid is high and ready
// is low. req_ready depends only on reset_n, resp_valid and resp_ready, never
// on req_valid, so no combinational loop can form through the requester.
// ---------------------------------------------------------------------------
module datamem_pipe #(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int READ_LAT  = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_size,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_write,
    output logic              resp_err,
    output logic [DATA_W-1:0] resp_rdata
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = $clog2(MEM_BYTES);

    // Byte storage; deliberately not reset so unwritten bytes read as X.
    logic [7:0]        r_mem [MEM_BYTES];

    logic              w_stall;
    logic              w_accept;
    logic              w_size_ok;
    logic              w_misaligned;
    logic              w_oob;
    logic              w_err;
    logic              w_wr_en;
    logic [ADDR_W:0]   w_end;
    logic [NB-1:0]     w_byte_en;
    logic [IDX_W-1:0]  w_idx [NB];
    logic              w_sign;
    logic [DATA_W-1:0] w_ext;

    // First pipeline stage (always present).
    logic              r_p1_valid;
    logic              r_p1_write;
    logic              r_p1_err;
    logic [DATA_W-1:0] r_p1_rdata;

    // A held response freezes the whole pipe, so nothing can be accepted.
    assign w_stall   = resp_valid && !resp_ready;
    assign req_ready = reset_n && !w_stall;
    assign w_accept  = req_valid && req_ready;

    // ------------------------------------------------------------------
    // Request checking
    // ------------------------------------------------------------------
    assign w_size_ok = ((req_size == 4'd1) || (req_size == 4'd2) ||
                        (req_size == 4'd4) || (req_size == 4'd8)) &&
                       ({1'b0, req_size} <= 5'(NB));

    // Only meaningful for a legal size; with size 1 the mask is zero.
    assign w_misaligned = (req_addr[3:0] & (req_size - 4'd1)) != 4'd0;

    // One extra bit so a request near the top of the address space cannot
    // wrap around and look in range.
    assign w_end = {1'b0, req_addr} + {{(ADDR_W-3){1'b0}}, req_size};
    assign w_oob = w_end > (ADDR_W+1)'(MEM_BYTES);

    assign w_err   = !w_size_ok || w_misaligned || w_oob;
    assign w_wr_en = w_accept && req_write && !w_err;

    // Per-byte lane enables and storage indices. Indices are truncated to
    // the storage width so an erroring request can never index past the
    // array; its data is discarded anyway.
    always_comb begin
        for (int i = 0; i < NB; i++) begin
            w_byte_en[i] = 4'(i) < req_size;
            w_idx[i]     = req_addr[IDX_W-1:0] + IDX_W'(i);
        end
    end

    // ------------------------------------------------------------------
    // Load data gather and extension
    // ------------------------------------------------------------------
    always_comb begin
        w_sign = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (4'(i + 1) == req_size) begin
                w_sign = r_mem[w_idx[i]][7];
            end
        end
    end

    always_comb begin
        w_ext = '0;
        for (int i = 0; i < NB; i++) begin
            if (w_byte_en[i]) begin
                w_ext[8*i +: 8] = r_mem[w_idx[i]];
            end else if (req_signed) begin
                w_ext[8*i +: 8] = {8{w_sign}};
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage write: committed on the accept edge, so a load accepted on
    // the following edge already sees the new bytes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (w_byte_en[i]) begin
                    r_mem[w_idx[i]] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: captures the response on the accept edge. An empty slot
    // carries all-zero payload so idle outputs read back as 0.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_p1_valid <= 1'b0;
            r_p1_write <= 1'b0;
            r_p1_err   <= 1'b0;
            r_p1_rdata <= '0;
        end else if (!w_stall) begin
            r_p1_valid <= w_accept;
            r_p1_write <= w_accept && req_write;
            r_p1_err   <= w_accept && w_err;
            r_p1_rdata <= (w_accept && !w_err && !req_write) ? w_ext : '0;
        end
    end

    // ------------------------------------------------------------------
    // Optional second stage for READ_LAT == 2
    // ------------------------------------------------------------------
    generate
        if (READ_LAT == 2) begin : g_lat2
            logic              r_p2_valid;
            logic              r_p2_write;
            logic              r_p2_err;
            logic [DATA_W-1:0] r_p2_rdata;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_p2_valid <= 1'b0;
                    r_p2_write <= 1'b0;
                    r_p2_err   <= 1'b0;
                    r_p2_rdata <= '0;
                end else if (!w_stall) begin
                    r_p2_valid <= r_p1_valid;
                    r_p2_write <= r_p1_write;
                    r_p2_err   <= r_p1_err;
                    r_p2_rdata <= r_p1_rdata;
                end
            end

            assign resp_valid = r_p2_valid;
            assign resp_write = r_p2_write;
            assign resp_err   = r_p2_err;
            assign resp_rdata = r_p2_rdata;
        end else begin : g_lat1
            assign resp_valid = r_p1_valid;
            assign resp_write = r_p1_write;
            assign resp_err   = r_p1_err;
            assign resp_rdata = r_p1_rdata;
        end
    endgenerate

endmodule

// File: tb/tb_datamem_pipe.sv
// ---------------------------------------------------------------------------
// tb_datamem_pipe
//
// Directed bench for datamem_pipe. Two instances are built, one with
// READ_LAT=1 (index 0) and one with READ_LAT=2 (index 1); the same directed
// sequence is run against each in turn while the other sits idle.
// ---------------------------------------------------------------------------
module tb_datamem_pipe;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int MB = 1024;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;

    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0]          req_write;
    logic [1:0]          req_signed;
    logic [1:0][AW-1:0]  req_addr;
    logic [1:0][3:0]     req_size;
    logic [1:0][DW-1:0]  req_wdata;
    logic [1:0]          resp_valid;
    logic [1:0]          resp_ready;
    logic [1:0]          resp_write;
    logic [1:0]          resp_err;
    logic [1:0][DW-1:0]  resp_rdata;

    int checks = 0;
    int errors = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    datamem_pipe #(.MEM_BYTES(MB), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(1)) u_lat1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid[0]),
        .req_ready  (req_ready[0]),
        .req_write  (req_write[0]),
        .req_signed (req_signed[0]),
        .req_addr   (req_addr[0]),
        .req_size   (req_size[0]),
        .req_wdata  (req_wdata[0]),
        .resp_valid (resp_valid[0]),
        .resp_ready (resp_ready[0]),
        .resp_write (resp_write[0]),
        .resp_err   (resp_err[0]),
        .resp_rdata (resp_rdata[0])
    );

    datamem_pipe #(.MEM_BYTES(MB), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(2)) u_lat2 (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid[1]),
        .req_ready  (req_ready[1]),
        .req_write  (req_write[1]),
        .req_signed (req_signed[1]),
        .req_addr   (req_addr[1]),
        .req_size   (req_size[1]),
        .req_wdata  (req_wdata[1]),
        .resp_valid (resp_valid[1]),
        .resp_ready (resp_ready[1]),
        .resp_write (resp_write[1]),
        .resp_err   (resp_err[1]),
        .resp_rdata (resp_rdata[1])
    );

    // ---------------- checking ----------------
    task automatic chk(input logic [63:0] got, input logic [63:0] exp,
                       input string tag, input int d);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s (lat%0d): got %h expected %h", tag, d + 1, got, exp);
        end
    endtask

    task automatic chk_resp(input int d, input logic wr, input logic err,
                            input logic [63:0] rd, input string tag);
        chk(resp_valid[d], 1'b1, {tag, ".valid"}, d);
        chk(resp_write[d], wr,   {tag, ".write"}, d);
        chk(resp_err[d],   err,  {tag, ".err"},   d);
        chk(resp_rdata[d], rd,   {tag, ".rdata"}, d);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input int d, input logic wr, input logic sg,
                         input logic [63:0] addr, input logic [3:0] size,
                         input logic [63:0] wdata);
        req_valid[d]  = 1'b1;
        req_write[d]  = wr;
        req_signed[d] = sg;
        req_addr[d]   = addr;
        req_size[d]   = size;
        req_wdata[d]  = wdata;
    endtask

    // One request, checked for READ_LAT latency and for the return to idle.
    task automatic single(input int d, input logic wr, input logic sg,
                          input logic [63:0] addr, input logic [3:0] size,
                          input logic [63:0] wdata, input logic exp_err,
                          input logic [63:0] exp_rd, input string tag);
        drive(d, wr, sg, addr, size, wdata);
        resp_ready[d] = 1'b1;
        #1;
        chk(req_ready[d], 1'b1, {tag, ".rdy"}, d);
        @(posedge clk); @(negedge clk);
        req_valid[d] = 1'b0;
        #1;
        if (d == 1) begin
            chk(resp_valid[d], 1'b0, {tag, ".early"}, d);
            @(posedge clk); @(negedge clk);
            #1;
        end
        chk_resp(d, wr, exp_err, exp_rd, tag);
        @(posedge clk); @(negedge clk);
        #1;
        chk(resp_valid[d], 1'b0, {tag, ".idle"}, d);
        chk(resp_rdata[d], 64'h0, {tag, ".idle_rd"}, d);
    endtask

    // Store then load to the same bytes on consecutive cycles.
    task automatic back_to_back(input int d);
        resp_ready[d] = 1'b1;
        drive(d, 1'b1, 1'b0, 64'h20, 4'd2, 64'hBEEF);
        @(posedge clk); @(negedge clk);
        drive(d, 1'b0, 1'b0, 64'h20, 4'd2, 64'h0);
        #1;
        if (d == 0) chk_resp(d, 1'b1, 1'b0, 64'h0, "b2b.st");
        else        chk(resp_valid[d], 1'b0, "b2b.early", d);
        @(posedge clk); @(negedge clk);
        req_valid[d] = 1'b0;
        #1;
        if (d == 0) chk_resp(d, 1'b0, 1'b0, 64'hBEEF, "b2b.ld");
        else        chk_resp(d, 1'b1, 1'b0, 64'h0, "b2b.st");
        @(posedge clk); @(negedge clk);
        #1;
        if (d == 1) chk_resp(d, 1'b0, 1'b0, 64'hBEEF, "b2b.ld");
        else        chk(resp_valid[d], 1'b0, "b2b.idle", d);
        @(posedge clk); @(negedge clk);
    endtask

    // Loads queued behind a held response; scoreboard tracks order.
    task automatic stall_test(input int d);
        logic [63:0] exp_q[$];
        logic [63:0] la[3];
        logic [63:0] le[3];
        logic [3:0]  ls[3];
        logic        lg[3];
        logic [63:0] snap_rd;
        logic [1:0]  snap_we;
        bit          was_stall = 0;
        int          sent = 0;
        int          got = 0;
        int          stall_cyc = 0;
        la[0] = 64'h10; ls[0] = 4'd8; lg[0] = 1'b0; le[0] = 64'h0123456789ABCDEF;
        la[1] = 64'h10; ls[1] = 4'd1; lg[1] = 1'b0; le[1] = 64'h00000000000000EF;
        la[2] = 64'h12; ls[2] = 4'd2; lg[2] = 1'b1; le[2] = 64'hFFFFFFFFFFFF89AB;
        for (int cyc = 0; cyc < 12; cyc++) begin
            resp_ready[d] = (cyc >= 5);
            if (sent < 3) drive(d, 1'b0, lg[sent], la[sent], ls[sent], 64'h0);
            else          req_valid[d] = 1'b0;
            #1;
            if (resp_valid[d] && !resp_ready[d]) begin
                stall_cyc++;
                chk(req_ready[d], 1'b0, "stall.rdy", d);
                if (was_stall) begin
                    chk(resp_rdata[d], snap_rd, "stall.hold_rd", d);
                    chk({resp_write[d], resp_err[d]}, snap_we, "stall.hold_we", d);
                end
                snap_rd   = resp_rdata[d];
                snap_we   = {resp_write[d], resp_err[d]};
                was_stall = 1;
            end else begin
                was_stall = 0;
            end
            if (resp_valid[d] && resp_ready[d]) begin
                chk(exp_q.size() > 0, 1'b1, "stall.dup", d);
                if (exp_q.size() > 0) begin
                    chk(resp_rdata[d], exp_q.pop_front(), "stall.data", d);
                    chk(resp_err[d], 1'b0, "stall.err", d);
                end
                got++;
            end
            if (req_valid[d] && req_ready[d]) begin
                exp_q.push_back(le[sent]);
                sent++;
            end
            @(posedge clk); @(negedge clk);
        end
        req_valid[d] = 1'b0;
        chk(got, 3, "stall.count", d);
        chk(exp_q.size(), 0, "stall.lost", d);
        chk(stall_cyc >= 3, 1'b1, "stall.cycles", d);
    endtask

    // Reset dropped while requests are in flight.
    task automatic reset_test(input int d);
        resp_ready[d] = 1'b1;
        drive(d, 1'b0, 1'b0, 64'h10, 4'd8, 64'h0);
        @(posedge clk); @(negedge clk);
        drive(d, 1'b0, 1'b0, 64'h10, 4'd1, 64'h0);
        @(posedge clk); @(negedge clk);
        req_valid[d] = 1'b0;
        #1;
        chk(resp_valid[d], 1'b1, "rst.pre", d);
        reset_n = 1'b0;
        #1;
        chk(resp_valid[d], 1'b0, "rst.async", d);
        chk(req_ready[d], 1'b0, "rst.rdy", d);
        chk(resp_rdata[d], 64'h0, "rst.rdata", d);
        @(posedge clk); @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); @(negedge clk);
            #1;
            chk(resp_valid[d], 1'b0, "rst.stale", d);
        end
        single(d, 1'b0, 1'b0, 64'h10, 4'd8, 64'h0, 1'b0, 64'h0123456789ABCDEF, "rst.keep");
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        req_valid  = '0;
        req_write  = '0;
        req_signed = '0;
        req_addr   = '0;
        req_size   = '0;
        req_wdata  = '0;
        resp_ready = '1;
        reset_n    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk(resp_valid[d], 1'b0,  "reset.valid", d);
            chk(resp_err[d],   1'b0,  "reset.err",   d);
            chk(resp_write[d], 1'b0,  "reset.write", d);
            chk(resp_rdata[d], 64'h0, "reset.rdata", d);
        end
        reset_n = 1'b1;

        for (int d = 0; d < 2; d++) begin
            // store then full-width load
            single(d, 1'b1, 1'b0, 64'h10, 4'd8, 64'h0123456789ABCDEF, 1'b0, 64'h0, "st8");
            single(d, 1'b0, 1'b0, 64'h10, 4'd8, 64'h0, 1'b0, 64'h0123456789ABCDEF, "ld8");
            // extension
            single(d, 1'b0, 1'b1, 64'h10, 4'd1, 64'h0, 1'b0, 64'hFFFFFFFFFFFFFFEF, "ld1s");
            single(d, 1'b0, 1'b0, 64'h10, 4'd1, 64'h0, 1'b0, 64'h00000000000000EF, "ld1u");
            single(d, 1'b0, 1'b1, 64'h16, 4'd2, 64'h0, 1'b0, 64'h0000000000000123, "ld2s");
            single(d, 1'b0, 1'b1, 64'h14, 4'd4, 64'h0, 1'b0, 64'h0000000001234567, "ld4s");
            single(d, 1'b0, 1'b1, 64'h12, 4'd2, 64'h0, 1'b0, 64'hFFFFFFFFFFFF89AB, "ld2s_neg");
            single(d, 1'b0, 1'b0, 64'h10, 4'd4, 64'h0, 1'b0, 64'h0000000089ABCDEF, "ld4u");
            // error cases leave storage untouched
            single(d, 1'b1, 1'b0, 64'h0,   4'd8, 64'h1122334455667788, 1'b0, 64'h0, "st_lo");
            single(d, 1'b1, 1'b0, 64'd1016, 4'd8, 64'hCAFEF00DDEADBEEF, 1'b0, 64'h0, "st_hi");
            single(d, 1'b1, 1'b0, 64'h6,   4'd4, 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'h0, "err_mis");
            single(d, 1'b1, 1'b0, 64'h0,   4'd3, 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'h0, "err_sz3");
            single(d, 1'b1, 1'b0, 64'd1020, 4'd8, 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'h0, "err_top");
            single(d, 1'b1, 1'b0, 64'd1024, 4'd8, 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'h0, "err_oob");
            single(d, 1'b0, 1'b1, 64'h0,   4'd0, 64'h0, 1'b1, 64'h0, "err_sz0");
            single(d, 1'b0, 1'b0, 64'h0,   4'd8, 64'h0, 1'b0, 64'h1122334455667788, "chk_lo");
            single(d, 1'b0, 1'b0, 64'd1016, 4'd8, 64'h0, 1'b0, 64'hCAFEF00DDEADBEEF, "chk_hi");
            // pipelining, backpressure, reset
            back_to_back(d);
            stall_test(d);
            reset_test(d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
